// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//   Receives a program image as a valid/ready byte stream and packs the bytes
//   big-endian into 32-bit instruction words. Each word is written to the next
//   consecutive imem word address. The CPU is held in reset while loading.
//   Frame: N[15:8], N[7:0], then 4*N data bytes, with the MSB of each word first.
// Parameters:
//   ADDR_W      imem word-address width (1..16); capacity = 2**ADDR_W words
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  when defined, a trailing checksum byte C follows
//                            the data. The 8-bit data-byte sum plus C must be
//                            8'h00, otherwise the load ends in the error state.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle pulse that begins a load (only when not busy)
//   rx_data/valid/ready byte stream input; a transfer is rx_valid & rx_ready
//   imem_we/addr/wdata  one-cycle word write to imem
//   cpu_hold            holds the CPU in reset while a load is in progress
//   done / error        level outputs giving the outcome of the last load
//   word_count          word count N taken from the frame header
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  localparam state_t FIN = CSUM;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif

  // Capacity, in 17 bits so that the largest N = 2**ADDR_W is still representable.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state, state_n;
  logic [7:0]        len_hi;
  logic [23:0]       shreg;      // first three bytes of the word being packed
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic              xfer;
  logic              start_ok;
  logic [15:0]       n_full;
  logic              too_big;
  logic              last_byte;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign xfer      = rx_valid & rx_ready;
  assign start_ok  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign n_full    = {len_hi, rx_data};
  assign too_big   = {1'b0, n_full} > CAP;
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (16'(word_idx) == (word_count - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_n = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_n = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (xfer) begin
          if (too_big)              state_n = ERR;
          else if (n_full == 16'd0) state_n = FIN;
          else                      state_n = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (xfer && last_byte && last_word) state_n = FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        rx_ready = 1'b1;
        if (xfer) state_n = (8'(sum + rx_data) == 8'h00) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Status flags lag the state by one cycle. As a result, done rises one
  // cycle after the final write strobe, and a restart clears the flags at
  // the same time that it raises cpu_hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi     <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
        word_idx <= '0;
        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end else if (state == DONE) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end else if (state == ERR) begin
        error    <= 1'b1;
      end

      if (xfer) begin
        case (state)
          LEN_HI: len_hi     <= rx_data;
          LEN_LO: word_count <= n_full;
          DATA: begin
            shreg    <= {shreg[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + rx_data;
`endif
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {shreg, rx_data};
              word_idx   <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [15:0]   word_count;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Write recorder: sampling on the falling edge shows each strobe cycle exactly once.
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] b;        // frame bytes, left-aligned
    logic [7:0]  c;        // checksum byte (sent only in checksum builds)
    bit          send_c;
    int          gap;
    int          start_at; // byte index at which start is pulsed, -1 = never
    int          nw;
    logic [31:0] w0, w1;
    logic        d, e;
    logic [15:0] wc;
  } vec_t;

  function automatic vec_t mk(string nm, int nb, logic [95:0] b, logic [7:0] c,
                              bit send_c, int gap, int start_at, int nw,
                              logic [31:0] w0, logic [31:0] w1,
                              logic d, logic e, logic [15:0] wc);
    vec_t v;
    v.name = nm; v.nb = nb; v.b = b; v.c = c; v.send_c = send_c;
    v.gap = gap; v.start_at = start_at; v.nw = nw; v.w0 = w0; v.w1 = w1;
    v.d = d; v.e = e; v.wc = wc;
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit s);
    int t = 0;
    repeat (gap) begin rx_valid = 1'b0; step(); end
    rx_valid = 1'b1; rx_data = b; start = s;
    while (!rx_ready && t < 50) begin step(); t++; end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    step();
    rx_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_start_hold"}, 32'(cpu_hold), 32'd1);
    chk({nm, "_start_done"}, 32'(done), 32'd0);
    chk({nm, "_start_err"},  32'(error), 32'd0);
  endtask

  task automatic wait_fin(input string nm);
    int t = 0;
    while (!(done | error) && t < 20) begin step(); t++; end
    if (t >= 20) chk({nm, "_fin_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  task automatic run_vec(input vec_t v);
    wa.delete(); wd.delete();
    do_start(v.name);
    for (int k = 0; k < v.nb; k++)
      send_byte(v.b[95 - 8*k -: 8], v.gap, (k == v.start_at));
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.send_c) send_byte(v.c, v.gap, 1'b0);
`endif
    wait_fin(v.name);
    chk({v.name, "_nwrites"}, 32'(wa.size()), 32'(v.nw));
    if (v.nw >= 1 && wa.size() >= 1) begin
      chk({v.name, "_addr0"}, 32'(wa[0]), 32'd0);
      chk({v.name, "_data0"}, wd[0], v.w0);
    end
    if (v.nw >= 2 && wa.size() >= 2) begin
      chk({v.name, "_addr1"}, 32'(wa[1]), 32'd1);
      chk({v.name, "_data1"}, wd[1], v.w1);
    end
    chk({v.name, "_done"},  32'(done), 32'(v.d));
    chk({v.name, "_error"}, 32'(error), 32'(v.e));
    chk({v.name, "_hold"},  32'(cpu_hold), 32'(v.e));
    chk({v.name, "_ready"}, 32'(rx_ready), 32'd0);
    chk({v.name, "_wc"},    32'(word_count), 32'(v.wc));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_we"},    32'(imem_we), 32'd0);
    chk({nm, "_addr"},  32'(imem_addr), 32'd0);
    chk({nm, "_wdata"}, imem_wdata, 32'd0);
    chk({nm, "_ready"}, 32'(rx_ready), 32'd0);
    chk({nm, "_hold"},  32'(cpu_hold), 32'd0);
    chk({nm, "_done"},  32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
    chk({nm, "_wc"},    32'(word_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [95:0] CASE1 = 96'h00022008000500000008_0000;

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk("case1", 10, CASE1, 8'hCB, 1, 0, -1, 2,
                      32'h20080005, 32'h00000008, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk("empty", 2, 96'h0, 8'h00, 1, 0, -1, 0,
                      32'h0, 32'h0, 1'b1, 1'b0, 16'd0));
    vecs.push_back(mk("toobig", 2, 96'h0101_0000_0000_0000_0000_0000, 8'h00, 0, 0, -1, 0,
                      32'h0, 32'h0, 1'b0, 1'b1, 16'h0101));
    vecs.push_back(mk("gaps", 10, CASE1, 8'hCB, 1, 3, 5, 2,
                      32'h20080005, 32'h00000008, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk("ones", 6, 96'h0001FFFFFFFF_000000000000, 8'h04, 1, 1, -1, 1,
                      32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 16'd1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk("badsum", 10, CASE1, 8'h00, 1, 0, -1, 2,
                      32'h20080005, 32'h00000008, 1'b0, 1'b1, 16'd2));
`endif

    reset = 1'b1;
    #1;
    chk_all_zero("por");
    step(); step();
    reset = 1'b0;
    step();
    chk_all_zero("idle");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a word: outputs clear at once and no write is issued.
    wa.delete(); wd.delete();
    do_start("rst");
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("rst_nowrite", 32'(wa.size()), 32'd0);
    run_vec(vecs[0]);

    // Full capacity: N = 256 must load and use the last address 255.
    begin
      logic [7:0]  s = 8'h00;
      logic [31:0] w;
      int          bad = 0;
      wa.delete(); wd.delete();
      do_start("full");
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      for (int i = 0; i < 256; i++) begin
        w = {8'(i), 8'(i * 3), 8'(255 - i), 8'h3C};
        for (int k = 0; k < 4; k++) begin
          send_byte(w[31 - 8*k -: 8], 0, 1'b0);
          s = s + w[31 - 8*k -: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'(8'h00 - s), 0, 1'b0);
`endif
      wait_fin("full");
      chk("full_nwrites", 32'(wa.size()), 32'd256);
      if (wa.size() == 256) begin
        for (int i = 0; i < 256; i++) begin
          w = {8'(i), 8'(i * 3), 8'(255 - i), 8'h3C};
          if (wa[i] !== 8'(i) || wd[i] !== w) bad++;
        end
        chk("full_words", 32'(bad), 32'd0);
        chk("full_lastaddr", 32'(wa[255]), 32'd255);
      end
      chk("full_done", 32'(done), 32'd1);
      chk("full_error", 32'(error), 32'd0);
      chk("full_wc", 32'(word_count), 32'd256);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
